// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshakes, broadcast
// mode and a saturating counter of words dropped for an out-of-range select.
module demux_stream_1xn #(
    parameter  int N      = 8,
    parameter  int W      = 8,
    parameter  int ERR_CW = 8,
    localparam int SEL_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_bcast,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N*W-1:0]    out_data,
    output logic [N-1:0]      out_valid,
    input  logic [N-1:0]      out_ready,
    output logic              err_flag,
    output logic [ERR_CW-1:0] err_cnt,
    input  logic              err_clr
);

    localparam logic [SEL_W:0] N_L = (SEL_W + 1)'(N);

    logic [N-1:0]      free_s;
    logic [N-1:0]      load_s;
    logic              in_range_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              drop_s;

    logic [N-1:0]      valid_d, valid_q;
    logic [N*W-1:0]    data_d, data_q;
    logic              err_flag_d, err_flag_q;
    logic [ERR_CW-1:0] err_cnt_d, err_cnt_q;

    // Input-side handshake: ready depends only on the select, mode and channel occupancy.
    always_comb begin
        free_s     = ~valid_q | out_ready;
        in_range_s = ({1'b0, in_sel} < N_L);
        if (in_bcast) begin
            in_ready_s = &free_s;
        end else if (in_range_s) begin
            in_ready_s = free_s[in_sel];
        end else begin
            in_ready_s = 1'b1;
        end
        accept_s = in_valid & in_ready_s;
        drop_s   = accept_s & ~in_bcast & ~in_range_s;
    end

    // Per-channel holding registers: reload wins over drain so a channel can refill in the same cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        load_s  = '0;
        for (int k = 0; k < N; k++) begin
            load_s[k] = accept_s & (in_bcast | (in_range_s & (in_sel == SEL_W'(k))));
            if (load_s[k]) begin
                valid_d[k]        = 1'b1;
                data_d[k*W +: W]  = in_data;
            end else if (out_ready[k]) begin
                valid_d[k]        = 1'b0;
            end else begin
                valid_d[k]        = valid_q[k];
            end
        end
    end

    // Error bookkeeping: clear has priority over a simultaneous drop.
    always_comb begin
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        if (err_clr) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end else if (drop_s) begin
            err_flag_d = 1'b1;
            err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CW'(1);
        end else begin
            err_flag_d = err_flag_q;
            err_cnt_d  = err_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            data_q     <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Scoreboard bench for demux_stream_1xn: one N=8 instance for routing and
// backpressure, two N=6 instances (ERR_CW=8 and ERR_CW=2) for out-of-range handling.
module tb_demux_stream_1xn;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N=8 instance
    logic [7:0]  d8_data;
    logic [2:0]  d8_sel;
    logic        d8_bcast, d8_valid, d8_in_ready, d8_clr;
    logic [63:0] d8_out_data;
    logic [7:0]  d8_out_valid, d8_oready;
    logic        d8_err_flag;
    logic [7:0]  d8_err_cnt;

    // N=6 instances share stimulus
    logic [7:0]  d6_data;
    logic [2:0]  d6_sel;
    logic        d6_bcast, d6_valid, d6_clr;
    logic [5:0]  d6_oready;
    logic        a_in_ready, b_in_ready, a_err_flag, b_err_flag;
    logic [47:0] a_out_data, b_out_data;
    logic [5:0]  a_out_valid, b_out_valid;
    logic [7:0]  a_err_cnt;
    logic [1:0]  b_err_cnt;

    demux_stream_1xn #(.N(8), .W(8), .ERR_CW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(d8_data), .in_sel(d8_sel), .in_bcast(d8_bcast),
        .in_valid(d8_valid), .in_ready(d8_in_ready), .out_data(d8_out_data),
        .out_valid(d8_out_valid), .out_ready(d8_oready), .err_flag(d8_err_flag),
        .err_cnt(d8_err_cnt), .err_clr(d8_clr));

    demux_stream_1xn #(.N(6), .W(8), .ERR_CW(8)) dut6a (
        .clk(clk), .rst_n(rst_n), .in_data(d6_data), .in_sel(d6_sel), .in_bcast(d6_bcast),
        .in_valid(d6_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(d6_oready), .err_flag(a_err_flag),
        .err_cnt(a_err_cnt), .err_clr(d6_clr));

    demux_stream_1xn #(.N(6), .W(8), .ERR_CW(2)) dut6b (
        .clk(clk), .rst_n(rst_n), .in_data(d6_data), .in_sel(d6_sel), .in_bcast(d6_bcast),
        .in_valid(d6_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(d6_oready), .err_flag(b_err_flag),
        .err_cnt(b_err_cnt), .err_clr(d6_clr));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         ch;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t mk(input int ch, input logic [7:0] d);
        exp_t e;
        e.ch = ch;
        e.d  = d;
        return e;
    endfunction

    // Monitor: every completed output transfer on dut8 must match the oldest expected word of that channel.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 8; k++) begin
                if (d8_out_valid[k] && d8_oready[k]) begin
                    bit found;
                    found = 1'b0;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (!found && sb[i].ch == k) begin
                            n_checks++;
                            if (d8_out_data[k*8 +: 8] !== sb[i].d)
                                $display("FAIL sb_data ch%0d: got %h expected %h", k, d8_out_data[k*8 +: 8], sb[i].d);
                            else
                                n_pass++;
                            sb.delete(i);
                            found = 1'b1;
                        end
                    end
                    if (!found) begin
                        n_checks++;
                        $display("FAIL sb_unexpected ch%0d: got %h expected no transfer", k, d8_out_data[k*8 +: 8]);
                    end
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        d8_data = 8'h00; d8_sel = 3'd0; d8_bcast = 1'b0; d8_valid = 1'b0; d8_clr = 1'b0;
        d8_oready = 8'hFF;
        d6_data = 8'h00; d6_sel = 3'd0; d6_bcast = 1'b0; d6_valid = 1'b0; d6_clr = 1'b0;
        d6_oready = 6'h3F;
        #3;
        n_checks++;
        if ({d8_out_valid, d8_out_data, d8_err_flag, d8_err_cnt} !== 81'd0)
            $display("FAIL reset_d8: got v=%h d=%h f=%b c=%h expected all 0", d8_out_valid, d8_out_data, d8_err_flag, d8_err_cnt);
        else n_pass++;
        n_checks++;
        if ({a_out_valid, a_err_flag, a_err_cnt, b_err_flag, b_err_cnt} !== 18'd0)
            $display("FAIL reset_d6: got v=%h f=%b c=%h fb=%b cb=%h expected all 0", a_out_valid, a_err_flag, a_err_cnt, b_err_flag, b_err_cnt);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_unicast_sweep;
        for (int k = 0; k < 8; k++) begin
            d8_sel = 3'(k); d8_data = 8'h10 + 8'(k); d8_valid = 1'b1;
            @(negedge clk);
            n_checks++;
            if (d8_in_ready !== 1'b1) $display("FAIL sweep_ready k=%0d: got %b expected 1", k, d8_in_ready);
            else n_pass++;
            n_checks++;
            if (d8_out_valid !== ((k == 0) ? 8'h00 : (8'h01 << (k - 1))))
                $display("FAIL sweep_valid k=%0d: got %h expected %h", k, d8_out_valid, (k == 0) ? 8'h00 : (8'h01 << (k - 1)));
            else n_pass++;
            sb.push_back(mk(k, 8'h10 + 8'(k)));
            step();
        end
        d8_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d8_out_valid !== 8'h80) $display("FAIL sweep_last: got %h expected 80", d8_out_valid);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (d8_out_valid !== 8'h00) $display("FAIL sweep_idle: got %h expected 00", d8_out_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_backpressure;
        d8_oready = 8'hF7;
        d8_sel = 3'd3; d8_data = 8'hAA; d8_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (d8_in_ready !== 1'b1) $display("FAIL bp_first_ready: got %b expected 1", d8_in_ready);
        else n_pass++;
        sb.push_back(mk(3, 8'hAA));
        step();
        d8_data = 8'hBB;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (d8_in_ready !== 1'b0) $display("FAIL bp_blocked c=%0d: got %b expected 0", c, d8_in_ready);
            else n_pass++;
            n_checks++;
            if (d8_out_valid !== 8'h08 || d8_out_data[31:24] !== 8'hAA)
                $display("FAIL bp_hold c=%0d: got v=%h d=%h expected v=08 d=aa", c, d8_out_valid, d8_out_data[31:24]);
            else n_pass++;
            step();
        end
        d8_oready = 8'hFF;
        @(negedge clk);
        n_checks++;
        if (d8_in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", d8_in_ready);
        else n_pass++;
        sb.push_back(mk(3, 8'hBB));
        step();
        d8_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d8_out_valid !== 8'h08 || d8_out_data[31:24] !== 8'hBB)
            $display("FAIL bp_second: got v=%h d=%h expected v=08 d=bb", d8_out_valid, d8_out_data[31:24]);
        else n_pass++;
        step();
    endtask

    task automatic test_broadcast;
        d8_oready = 8'hDF;
        d8_sel = 3'd5; d8_data = 8'h55; d8_valid = 1'b1;
        @(negedge clk);
        sb.push_back(mk(5, 8'h55));
        step();
        d8_bcast = 1'b1; d8_data = 8'h5C; d8_sel = 3'd1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (d8_in_ready !== 1'b0 || d8_out_valid !== 8'h20)
                $display("FAIL bc_blocked c=%0d: got r=%b v=%h expected r=0 v=20", c, d8_in_ready, d8_out_valid);
            else n_pass++;
            step();
        end
        d8_oready = 8'hFF;
        @(negedge clk);
        n_checks++;
        if (d8_in_ready !== 1'b1) $display("FAIL bc_ready: got %b expected 1", d8_in_ready);
        else n_pass++;
        for (int k = 0; k < 8; k++) sb.push_back(mk(k, 8'h5C));
        step();
        d8_valid = 1'b0; d8_bcast = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d8_out_valid !== 8'hFF || d8_out_data !== {8{8'h5C}})
            $display("FAIL bc_all: got v=%h d=%h expected v=ff d=5c.. ", d8_out_valid, d8_out_data);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (d8_out_valid !== 8'h00) $display("FAIL bc_drain: got %h expected 00", d8_out_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_out_of_range;
        d6_valid = 1'b1; d6_sel = 3'd6; d6_data = 8'h61;
        @(negedge clk);
        n_checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) $display("FAIL oor_ready6: got %b%b expected 11", a_in_ready, b_in_ready);
        else n_pass++;
        step();
        d6_sel = 3'd7; d6_data = 8'h62;
        @(negedge clk);
        n_checks++;
        if (a_in_ready !== 1'b1) $display("FAIL oor_ready7: got %b expected 1", a_in_ready);
        else n_pass++;
        step();
        d6_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_out_valid !== 6'h00 || a_err_flag !== 1'b1 || a_err_cnt !== 8'd2)
            $display("FAIL oor_two: got v=%h f=%b c=%0d expected v=00 f=1 c=2", a_out_valid, a_err_flag, a_err_cnt);
        else n_pass++;
        step();
        d6_valid = 1'b1; d6_sel = 3'd7; d6_clr = 1'b1;
        step();
        d6_valid = 1'b0; d6_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_err_flag !== 1'b0 || a_err_cnt !== 8'd0 || b_err_flag !== 1'b0 || b_err_cnt !== 2'd0)
            $display("FAIL oor_clear: got f=%b c=%0d fb=%b cb=%0d expected all 0", a_err_flag, a_err_cnt, b_err_flag, b_err_cnt);
        else n_pass++;
        step();
    endtask

    task automatic test_saturation;
        d6_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d6_sel = (i % 2 == 0) ? 3'd6 : 3'd7;
            step();
        end
        d6_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_err_cnt !== 2'd3 || b_err_flag !== 1'b1) $display("FAIL sat_cnt2: got c=%0d f=%b expected c=3 f=1", b_err_cnt, b_err_flag);
        else n_pass++;
        n_checks++;
        if (a_err_cnt !== 8'd5 || a_out_valid !== 6'h00) $display("FAIL sat_cnt8: got c=%0d v=%h expected c=5 v=00", a_err_cnt, a_out_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_midflight;
        d8_oready = 8'hFB;
        d8_sel = 3'd2; d8_data = 8'h77; d8_valid = 1'b1;
        step();
        d8_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d8_out_valid !== 8'h04 || d8_out_data[23:16] !== 8'h77)
            $display("FAIL mid_hold: got v=%h d=%h expected v=04 d=77", d8_out_valid, d8_out_data[23:16]);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (d8_out_valid !== 8'h00 || d8_out_data !== 64'd0)
            $display("FAIL mid_async: got v=%h d=%h expected 0", d8_out_valid, d8_out_data);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        d8_oready = 8'hFF;
        d8_sel = 3'd2; d8_data = 8'h99; d8_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (d8_in_ready !== 1'b1) $display("FAIL mid_ready: got %b expected 1", d8_in_ready);
        else n_pass++;
        sb.push_back(mk(2, 8'h99));
        step();
        d8_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d8_out_valid !== 8'h04 || d8_out_data[23:16] !== 8'h99)
            $display("FAIL mid_after: got v=%h d=%h expected v=04 d=99", d8_out_valid, d8_out_data[23:16]);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_unicast_sweep();
        test_backpressure();
        test_broadcast();
        test_out_of_range();
        test_saturation();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
